// File: rtl/alsu_hs.sv
// Handshaked arithmetic/logic/shift unit: W-bit operands, 2W-bit result,
// iterative shift-add multiply, error flag and LED blink while the last result is in error.
module alsu_hs #(
    parameter int    W              = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_DIV        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [2:0]        opcode,
    input  logic              cin,
    input  logic              serial_in,
    input  logic              direction,
    input  logic              red_op_a,
    input  logic              red_op_b,
    input  logic              bypass_a,
    input  logic              bypass_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out,
    output logic              err,
    output logic              busy,
    output logic [15:0]       leds
);

    localparam int RW     = 2 * W;
    localparam int CNT_W  = $clog2(W);
    localparam int LED_CW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
    localparam bit PRIO_A = (INPUT_PRIORITY == "A");
    localparam bit PRIO_B = (INPUT_PRIORITY == "B");
    localparam bit FA_ON  = (FULL_ADDER == "ON");
    localparam bit FA_OFF = (FULL_ADDER == "OFF");
    localparam logic [CNT_W-1:0]  MUL_LAST = CNT_W'(W - 1);
    localparam logic [LED_CW-1:0] LED_LAST = LED_CW'(LED_DIV - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t state_reg, state_next;

    logic [W-1:0]      a_reg, b_reg;
    logic [2:0]        opcode_reg;
    logic              cin_reg, serial_reg, dir_reg;
    logic              red_a_reg, red_b_reg, byp_a_reg, byp_b_reg;
    logic [RW-1:0]     out_reg, acc_reg, mcand_reg;
    logic [W-1:0]      mplier_reg;
    logic [CNT_W-1:0]  mul_cnt_reg;
    logic              err_reg, out_valid_reg;
    logic [15:0]       leds_reg;
    logic [LED_CW-1:0] led_cnt_reg;

    logic [RW-1:0] a_ext, b_ext, cin_ext, red_ext, add_result, exec_result;
    logic [RW-1:0] acc_sum, done_out;
    logic          invalid, red_a_val, red_b_val, red_bit;
    logic          exec_err, exec_to_mul, mul_last, complete, done_err;

    assign a_ext    = {{W{1'b0}}, a_reg};
    assign b_ext    = {{W{1'b0}}, b_reg};
    assign cin_ext  = {{(RW-1){1'b0}}, cin_reg};
    assign invalid  = (opcode_reg[2:1] == 2'b11) ||
                      ((red_a_reg || red_b_reg) && (opcode_reg[2:1] != 2'b00));

    // opcode bit 0 distinguishes AND (0) from XOR (1) reductions
    assign red_a_val = opcode_reg[0] ? ^a_reg : &a_reg;
    assign red_b_val = opcode_reg[0] ? ^b_reg : &b_reg;

    always_comb begin
        red_bit = 1'b0;
        if (red_a_reg && red_b_reg)
            red_bit = PRIO_A ? red_a_val : (PRIO_B ? red_b_val : 1'b0);
        else if (red_a_reg)
            red_bit = red_a_val;
        else
            red_bit = red_b_val;
    end

    assign red_ext    = {{(RW-1){1'b0}}, red_bit};
    assign add_result = FA_ON  ? (a_ext + b_ext + cin_ext) :
                        FA_OFF ? (a_ext + b_ext) : '0;

    always_comb begin
        exec_result = '0;
        exec_err    = 1'b0;
        exec_to_mul = 1'b0;
        if (byp_a_reg && byp_b_reg)
            exec_result = PRIO_A ? a_ext : (PRIO_B ? b_ext : '0);
        else if (byp_a_reg)
            exec_result = a_ext;
        else if (byp_b_reg)
            exec_result = b_ext;
        else if (invalid)
            exec_err = 1'b1;
        else begin
            case (opcode_reg)
                3'd0: exec_result = (red_a_reg || red_b_reg) ? red_ext : (a_ext & b_ext);
                3'd1: exec_result = (red_a_reg || red_b_reg) ? red_ext : (a_ext ^ b_ext);
                3'd2: exec_result = add_result;
                3'd3: exec_to_mul = 1'b1;
                3'd4: exec_result = dir_reg ? {out_reg[RW-2:0], serial_reg}
                                            : {serial_reg, out_reg[RW-1:1]};
                3'd5: exec_result = dir_reg ? {out_reg[RW-2:0], out_reg[RW-1]}
                                            : {out_reg[0], out_reg[RW-1:1]};
                default: exec_result = '0;
            endcase
        end
    end

    assign acc_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_last = (mul_cnt_reg == MUL_LAST);
    assign complete = ((state_reg == EXEC) && !exec_to_mul) || ((state_reg == MUL) && mul_last);
    assign done_out = (state_reg == MUL) ? acc_sum : exec_result;
    assign done_err = (state_reg == MUL) ? 1'b0 : exec_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = EXEC;
            EXEC: state_next = exec_to_mul ? MUL : DONE;
            MUL:  if (mul_last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == IDLE);
        busy     = (state_reg != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            opcode_reg    <= '0;
            cin_reg       <= 1'b0;
            serial_reg    <= 1'b0;
            dir_reg       <= 1'b0;
            red_a_reg     <= 1'b0;
            red_b_reg     <= 1'b0;
            byp_a_reg     <= 1'b0;
            byp_b_reg     <= 1'b0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            mul_cnt_reg   <= '0;
            out_reg       <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            leds_reg      <= '0;
            led_cnt_reg   <= '0;
        end else begin
            if ((state_reg == IDLE) && in_valid) begin
                a_reg      <= a;
                b_reg      <= b;
                opcode_reg <= opcode;
                cin_reg    <= cin;
                serial_reg <= serial_in;
                dir_reg    <= direction;
                red_a_reg  <= red_op_a;
                red_b_reg  <= red_op_b;
                byp_a_reg  <= bypass_a;
                byp_b_reg  <= bypass_b;
            end
            if ((state_reg == EXEC) && exec_to_mul) begin
                acc_reg     <= '0;
                mcand_reg   <= a_ext;
                mplier_reg  <= b_reg;
                mul_cnt_reg <= '0;
            end
            if (state_reg == MUL) begin
                acc_reg     <= acc_sum;
                mcand_reg   <= {mcand_reg[RW-2:0], 1'b0};
                mplier_reg  <= mplier_reg >> 1;
                mul_cnt_reg <= mul_cnt_reg + CNT_W'(1);
            end
            if (complete) begin
                out_reg       <= done_out;
                err_reg       <= done_err;
                out_valid_reg <= 1'b1;
            end else if ((state_reg == DONE) && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // a fresh completion restarts the blink phase; a clean one also blanks the bank
            if (complete) begin
                led_cnt_reg <= '0;
                if (!done_err)
                    leds_reg <= '0;
            end else if (err_reg) begin
                if (led_cnt_reg == LED_LAST) begin
                    led_cnt_reg <= '0;
                    leds_reg    <= ~leds_reg;
                end else begin
                    led_cnt_reg <= led_cnt_reg + LED_CW'(1);
                end
            end
        end
    end

    assign out       = out_reg;
    assign err       = err_reg;
    assign out_valid = out_valid_reg;
    assign leds      = leds_reg;

endmodule

// File: tb/tb_alsu_hs.sv
// Directed-vector bench for alsu_hs: a cycle-indexed transaction model checks every
// output on every cycle, with literal spot checks on results, LEDs and reset.
module tb_alsu_hs;

    localparam int W       = 3;
    localparam int RW      = 2 * W;
    localparam int LED_DIV = 4;
    localparam int MASK    = (1 << RW) - 1;
    localparam int ONES    = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    opcode = '0;
    logic          cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
    logic          red_op_a = 1'b0, red_op_b = 1'b0, bypass_a = 1'b0, bypass_b = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] out;
    logic          err, busy;
    logic [15:0]   leds;

    alsu_hs #(.W(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_DIV(LED_DIV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_a(red_op_a), .red_op_b(red_op_b),
        .bypass_a(bypass_a), .bypass_b(bypass_b), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .err(err), .busy(busy), .leds(leds)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails   = 0;

    // transaction model: cycle of accept, of result, of handshake
    int   accept_cyc = 0, done_cyc = 0, hs_cyc = 0, err_cyc = 0;
    int   cur_out = 0, nxt_out = 0;
    bit   cur_err = 0, nxt_err = 0, committed = 1, started = 0;
    logic [15:0] exp_leds = '0, led_base = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input int ia, ib, iop, icin, isin, idir, ira, irb, iba, ibb,
                                  input int prev, output int res, output bit e, output int lat);
        lat = 1;
        e   = 0;
        res = 0;
        if (iba != 0)
            res = ia;
        else if (ibb != 0)
            res = ib;
        else if (iop >= 6 || ((ira != 0 || irb != 0) && iop > 1))
            e = 1;
        else begin
            case (iop)
                0: res = (ira != 0) ? int'(ia == ONES) : (irb != 0) ? int'(ib == ONES) : (ia & ib);
                1: res = (ira != 0) ? ($countones(ia) % 2) : (irb != 0) ? ($countones(ib) % 2) : (ia ^ ib);
                2: res = ia + ib + icin;
                3: begin res = ia * ib; lat = 1 + W; end
                4: res = (idir != 0) ? (((prev << 1) | isin) & MASK) : ((prev >> 1) | (isin << (RW - 1)));
                5: res = (idir != 0) ? (((prev << 1) | (prev >> (RW - 1))) & MASK)
                                     : ((prev >> 1) | ((prev & 1) << (RW - 1)));
                default: res = 0;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        bit pend, vld;
        if (!rst && started) begin
            if (!committed && cyc >= done_cyc) begin
                if (nxt_err) begin
                    led_base = exp_leds;
                    err_cyc  = cyc;
                end
                cur_out   = nxt_out;
                cur_err   = nxt_err;
                committed = 1;
            end
            exp_leds = cur_err ? (led_base ^ ((((cyc - err_cyc) / LED_DIV) % 2 == 1) ? 16'hFFFF : 16'h0000))
                               : 16'h0000;
            pend = (cyc >= accept_cyc) && (cyc < hs_cyc);
            vld  = (cyc >= done_cyc) && (cyc < hs_cyc);
            chk("in_ready", 32'(in_ready), 32'(!pend));
            chk("busy", 32'(busy), 32'(pend));
            chk("out_valid", 32'(out_valid), 32'(vld));
            chk("out", 32'(out), 32'(cur_out));
            chk("err", 32'(err), 32'(cur_err));
            chk("leds", 32'(leds), 32'(exp_leds));
        end
    end

    task automatic issue(input int ia, ib, iop, icin, isin, idir, ira, irb, iba, ibb, input int stall);
        int  res, lat;
        bit  e, acc;
        a = 3'(ia); b = 3'(ib); opcode = 3'(iop); cin = 1'(icin); serial_in = 1'(isin);
        direction = 1'(idir); red_op_a = 1'(ira); red_op_b = 1'(irb);
        bypass_a = 1'(iba); bypass_b = 1'(ibb);
        in_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            fails++;
            $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
            $fatal(1, "request never accepted");
        end
        @(posedge clk); #1;
        model(ia, ib, iop, icin, isin, idir, ira, irb, iba, ibb, cur_out, res, e, lat);
        accept_cyc = cyc;
        done_cyc   = cyc + lat;
        hs_cyc     = done_cyc + 1 + stall;
        nxt_out    = res;
        nxt_err    = e;
        committed  = 0;
        in_valid   = 1'b0;
        out_ready  = (stall == 0);
    endtask

    task automatic wait_done(input int lit_out, input bit lit_err);
        int guard = 0;
        while (cyc < hs_cyc - 1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("lit_valid", 32'(out_valid), 32'd1);
        chk("lit_out", 32'(out), 32'(lit_out));
        chk("lit_err", 32'(err), 32'(lit_err));
        @(posedge clk); #1;
    endtask

    task automatic run(input int ia, ib, iop, icin, isin, idir, ira, irb, iba, ibb,
                       input int stall, input int lit_out, input bit lit_err);
        issue(ia, ib, iop, icin, isin, idir, ira, irb, iba, ibb, stall);
        wait_done(lit_out, lit_err);
    endtask

    task automatic model_reset();
        accept_cyc = 0; done_cyc = 0; hs_cyc = 0;
        cur_out = 0; cur_err = 0; committed = 1;
        led_base = '0; exp_leds = '0;
    endtask

    initial begin
        int d;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        started = 1;
        repeat (2) @(posedge clk);
        #1;
        //   a  b  op cin sin dir ra rb ba bb stall  out err
        run(5, 6, 0, 0,  0,  0,  0, 0, 0, 0, 0,     4,  0);
        run(5, 3, 1, 0,  0,  0,  0, 0, 0, 0, 0,     6,  0);
        run(6, 7, 0, 0,  0,  0,  1, 1, 0, 0, 0,     0,  0);
        run(7, 0, 0, 0,  0,  0,  1, 0, 0, 0, 0,     1,  0);
        run(0, 4, 1, 0,  0,  0,  0, 1, 0, 0, 0,     1,  0);
        run(7, 7, 3, 0,  0,  0,  0, 0, 0, 0, 0,     49, 0);
        run(5, 6, 3, 0,  0,  0,  0, 0, 0, 0, 0,     30, 0);
        run(7, 7, 2, 1,  0,  0,  0, 0, 0, 0, 5,     15, 0);
        run(3, 4, 2, 0,  0,  0,  0, 0, 0, 0, 0,     7,  0);
        run(0, 0, 6, 0,  0,  0,  0, 0, 0, 0, 0,     0,  1);
        d = done_cyc;
        while (cyc < d + LED_DIV) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("leds_on", 32'(leds), 32'h0000FFFF);
        while (cyc < d + 2 * LED_DIV) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("leds_off", 32'(leds), 32'd0);
        @(posedge clk); #1;
        run(1, 1, 2, 0,  0,  0,  1, 0, 0, 0, 0,     0,  1);
        repeat (5) @(posedge clk);
        #1;
        run(3, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0,     1,  0);
        chk("leds_clear", 32'(leds), 32'd0);
        run(0, 0, 4, 0,  1,  1,  0, 0, 0, 0, 0,     3,  0);
        run(0, 0, 5, 0,  0,  0,  0, 0, 0, 0, 0,     33, 0);
        run(0, 0, 4, 0,  1,  0,  0, 0, 0, 0, 0,     48, 0);
        run(0, 0, 5, 0,  0,  1,  0, 0, 0, 0, 0,     33, 0);
        run(2, 5, 0, 0,  0,  0,  0, 0, 1, 1, 0,     2,  0);
        run(2, 5, 7, 0,  0,  0,  0, 0, 0, 1, 0,     5,  0);
        run(2, 6, 1, 0,  0,  0,  0, 0, 1, 0, 0,     2,  0);
        // abandon a multiply in its second iteration
        issue(5, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_leds", 32'(leds), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(3, 2, 3, 0,  0,  0,  0, 0, 0, 0, 0,     6,  0);
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
